// File: rtl/seven_seg_capture.sv
// Samples a multiplexed active-low 7-segment display bus and rebuilds full 4-digit frames.
// A digit is captured once its {an,seg,dp} pattern has held for SETTLE cycles.
module seven_seg_capture #(
    parameter int unsigned SETTLE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    input  logic        dp,
    output logic [15:0] digits,
    output logic [3:0]  dps,
    output logic        valid,
    output logic        err
);
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [11:0] IDLE_PAT    = {4'hF, 7'h7F, 1'b1};

    logic [11:0] prev_q, prev_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        armed_q, armed_d;
    logic [15:0] shadow_q, shadow_d;
    logic [3:0]  sdp_q, sdp_d;
    logic [3:0]  seen_q, seen_d;
    logic        ferr_q, ferr_d;
    logic [15:0] digits_q, digits_d;
    logic [3:0]  dps_q, dps_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    logic [3:0]  code;
    logic        code_bad;
    logic [2:0]  lows;
    logic        change;
    logic        at_point;

    always_comb begin
        code     = 4'hE;
        code_bad = 1'b0;
        case (seg)
            7'b0000001: code = 4'h0;
            7'b1001111: code = 4'h1;
            7'b0010010: code = 4'h2;
            7'b0000110: code = 4'h3;
            7'b1001100: code = 4'h4;
            7'b0100100: code = 4'h5;
            7'b0100000: code = 4'h6;
            7'b0001111: code = 4'h7;
            7'b0000000: code = 4'h8;
            7'b0000100: code = 4'h9;
            7'b1111111: code = 4'hF;
            default:    code_bad = 1'b1;
        endcase
    end

    always_comb begin
        lows = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            lows = lows + {2'b00, ~an[i]};
        end
    end

    always_comb begin
        prev_d   = {an, seg, dp};
        change   = prev_d != prev_q;
        cnt_d    = change ? '0 : ((cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1);
        armed_d  = armed_q | change;
        // cnt_d is this cycle's count, so SETTLE=1 fires in the change cycle itself
        at_point = armed_d && (cnt_d == SETTLE_LAST);
        shadow_d = shadow_q;
        sdp_d    = sdp_q;
        seen_d   = seen_q;
        ferr_d   = ferr_q;
        digits_d = digits_q;
        dps_d    = dps_q;
        err_d    = err_q;
        valid_d  = 1'b0;

        if (at_point && lows != 3'd0) begin
            armed_d = 1'b0;
            if (lows == 3'd1) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (!an[i]) begin
                        shadow_d[4*i +: 4] = code;
                        sdp_d[i]           = ~dp;
                        seen_d[i]          = 1'b1;
                    end
                end
                if (code_bad) begin
                    ferr_d = 1'b1;
                end
            end else begin
                ferr_d = 1'b1;
            end
        end

        if (seen_d == 4'hF) begin
            digits_d = shadow_d;
            dps_d    = sdp_d;
            err_d    = ferr_d;
            valid_d  = 1'b1;
            seen_d   = '0;
            ferr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q   <= IDLE_PAT;
            cnt_q    <= '0;
            armed_q  <= 1'b1;
            shadow_q <= '1;
            sdp_q    <= '0;
            seen_q   <= '0;
            ferr_q   <= 1'b0;
            digits_q <= '1;
            dps_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
            shadow_q <= shadow_d;
            sdp_q    <= sdp_d;
            seen_q   <= seen_d;
            ferr_q   <= ferr_d;
            digits_q <= digits_d;
            dps_q    <= dps_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign digits = digits_q;
    assign dps    = dps_q;
    assign valid  = valid_q;
    assign err    = err_q;
endmodule

// File: tb/tb_seven_seg_capture.sv
// Drives two captures (SETTLE=4 and SETTLE=1) from one display bus and compares
// both against a run-length reference model every cycle.
module tb_seven_seg_capture;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [15:0] digits4, digits1;
    logic [3:0]  dps4, dps1;
    logic        valid4, valid1, err4, err1;

    int n_chk = 0;
    int n_bad = 0;
    int vcnt4 = 0;
    int vcnt1 = 0;

    always #5 clk = ~clk;

    seven_seg_capture #(.SETTLE(4)) dut4 (
        .clk(clk), .reset(reset), .an(an), .seg(seg), .dp(dp),
        .digits(digits4), .dps(dps4), .valid(valid4), .err(err4)
    );
    seven_seg_capture #(.SETTLE(1)) dut1 (
        .clk(clk), .reset(reset), .an(an), .seg(seg), .dp(dp),
        .digits(digits1), .dps(dps1), .valid(valid1), .err(err1)
    );

    logic [6:0] seg_of [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    int          settle_k [2] = '{4, 1};
    logic [11:0] m_prev [2];
    int          m_run [2];
    logic [15:0] m_shadow [2];
    logic [3:0]  m_sdp [2];
    logic [3:0]  m_seen [2];
    logic        m_ferr [2];
    logic [15:0] e_digits [2];
    logic [3:0]  e_dps [2];
    logic        e_err [2];
    logic        e_valid [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void decode(input logic [6:0] s, output logic [3:0] c, output logic bad);
        c = 4'hE;
        bad = 1'b1;
        if (s == 7'h7F) begin
            c = 4'hF;
            bad = 1'b0;
        end
        for (int v = 0; v < 10; v++) begin
            if (s == seg_of[v]) begin
                c = 4'(v);
                bad = 1'b0;
            end
        end
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_prev[k] = 12'hFFF;
            m_run[k] = 1;
            m_shadow[k] = 16'hFFFF;
            m_sdp[k] = 4'h0;
            m_seen[k] = 4'h0;
            m_ferr[k] = 1'b0;
            e_digits[k] = 16'hFFFF;
            e_dps[k] = 4'h0;
            e_err[k] = 1'b0;
            e_valid[k] = 1'b0;
        end
    endtask

    // A pattern is captured once per run, on the cycle its run length reaches SETTLE.
    task automatic model_step(input int k);
        logic [11:0] cur;
        int lows;
        int idx;
        logic [3:0] c;
        logic bad;
        cur = {an, seg, dp};
        idx = 0;
        if (cur != m_prev[k]) m_run[k] = 1;
        else if (m_run[k] < 1000) m_run[k]++;
        m_prev[k] = cur;
        e_valid[k] = 1'b0;
        if (m_run[k] == settle_k[k]) begin
            lows = 4 - $countones(an);
            if (lows == 1) begin
                for (int i = 0; i < 4; i++) if (!an[i]) idx = i;
                decode(seg, c, bad);
                m_shadow[k][idx*4 +: 4] = c;
                m_sdp[k][idx] = ~dp;
                m_seen[k][idx] = 1'b1;
                if (bad) m_ferr[k] = 1'b1;
                if (m_seen[k] == 4'hF) begin
                    e_digits[k] = m_shadow[k];
                    e_dps[k] = m_sdp[k];
                    e_err[k] = m_ferr[k];
                    e_valid[k] = 1'b1;
                    m_seen[k] = 4'h0;
                    m_ferr[k] = 1'b0;
                end
            end else if (lows >= 2) begin
                m_ferr[k] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        check("s4.digits", digits4, e_digits[0]);
        check("s4.dps", dps4, e_dps[0]);
        check("s4.err", err4, e_err[0]);
        check("s4.valid", valid4, e_valid[0]);
        check("s1.digits", digits1, e_digits[1]);
        check("s1.dps", dps1, e_dps[1]);
        check("s1.err", err1, e_err[1]);
        check("s1.valid", valid1, e_valid[1]);
    endtask

    task automatic run_cycles(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
        for (int c = 0; c < n; c++) begin
            an = a;
            seg = s;
            dp = d;
            @(posedge clk);
            model_step(0);
            model_step(1);
            #1;
            check_all();
            if (valid4) vcnt4++;
            if (valid1) vcnt1++;
        end
    endtask

    task automatic show(input int idx, input int val, input logic d, input int n);
        logic [3:0] a;
        a = 4'hF;
        a[idx] = 1'b0;
        run_cycles(a, seg_of[val], d, n);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        an = 4'hF;
        seg = 7'h7F;
        dp = 1'b1;
        #1;
        model_reset();
        check("rst.s4.digits", digits4, 16'hFFFF);
        check("rst.s4.dps", dps4, 4'h0);
        check("rst.s4.valid", valid4, 1'b0);
        check("rst.s1.digits", digits1, 16'hFFFF);
        check("rst.s1.err", err1, 1'b0);
        @(posedge clk);
        #1;
        check("rst_hold.s4.digits", digits4, 16'hFFFF);
        check("rst_hold.s4.err", err4, 1'b0);
        reset = 1'b0;
        vcnt4 = 0;
        vcnt1 = 0;
    endtask

    initial begin
        logic [3:0] ra;
        logic [6:0] rs;
        int r;
        an = 4'hF;
        seg = 7'h7F;
        dp = 1'b1;
        #2;
        do_reset();

        run_cycles(4'hF, 7'h7F, 1'b1, 2);
        show(0, 4, 1'b1, 8); show(1, 3, 1'b1, 8); show(2, 2, 1'b1, 8); show(3, 1, 1'b1, 8);
        check("basic.vcnt4", vcnt4, 1);
        check("basic.vcnt1", vcnt1, 1);
        check("basic.digits", digits4, 16'h1234);
        check("basic.dps", dps4, 4'h0);
        check("basic.err", err4, 1'b0);

        do_reset();
        show(0, 9, 1'b1, 3); show(1, 1, 1'b1, 8); show(2, 2, 1'b1, 8); show(3, 3, 1'b1, 8);
        check("short.vcnt4", vcnt4, 0);
        show(0, 0, 1'b1, 8);
        check("short.done_vcnt4", vcnt4, 1);
        check("short.digits", digits4, 16'h3210);

        do_reset();
        show(0, 5, 1'b0, 8); show(1, 6, 1'b1, 8);
        run_cycles(4'b1011, 7'b1111110, 1'b1, 8);
        show(3, 7, 1'b1, 8);
        check("badseg.vcnt4", vcnt4, 1);
        check("badseg.digit2", 32'(digits4[11:8]), 4'hE);
        check("badseg.dps", dps4, 4'b0001);
        check("badseg.err", err4, 1'b1);
        show(0, 0, 1'b1, 8); show(1, 1, 1'b1, 8); show(2, 2, 1'b1, 8); show(3, 3, 1'b1, 8);
        check("clean.err", err4, 1'b0);
        check("clean.digits", digits4, 16'h3210);

        do_reset();
        show(0, 1, 1'b1, 8); show(1, 2, 1'b1, 8);
        run_cycles(4'b1100, seg_of[8], 1'b1, 8);
        show(2, 3, 1'b1, 8); show(3, 4, 1'b1, 8);
        check("multi.vcnt4", vcnt4, 1);
        check("multi.err", err4, 1'b1);
        check("multi.digits", digits4, 16'h4321);

        do_reset();
        show(0, 1, 1'b1, 8); show(1, 2, 1'b1, 8);
        do_reset();
        show(0, 8, 1'b1, 8); show(1, 7, 1'b1, 8); show(2, 6, 1'b1, 8);
        check("midrst.early_vcnt4", vcnt4, 0);
        show(3, 5, 1'b1, 8);
        check("midrst.vcnt4", vcnt4, 1);
        check("midrst.digits", digits4, 16'h5678);
        check("midrst.err", err4, 1'b0);

        do_reset();
        run_cycles(4'hF, 7'h7F, 1'b1, 1);
        show(0, 1, 1'b1, 1); show(1, 2, 1'b1, 1); show(2, 3, 1'b1, 1); show(3, 4, 1'b1, 1);
        check("fast.valid1", valid1, 1'b1);
        check("fast.digits1", digits1, 16'h4321);
        run_cycles(4'hF, 7'h7F, 1'b1, 2);
        check("fast.valid1_low", valid1, 1'b0);
        check("fast.vcnt1", vcnt1, 1);

        do_reset();
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 19);
            if (r < 16) begin
                ra = 4'hF;
                ra[$urandom_range(0, 3)] = 1'b0;
            end else if (r < 18) begin
                ra = 4'hF;
            end else begin
                ra = 4'($urandom);
            end
            r = $urandom_range(0, 19);
            if (r < 17) rs = seg_of[$urandom_range(0, 9)];
            else if (r == 17) rs = 7'h7F;
            else rs = 7'($urandom);
            run_cycles(ra, rs, 1'($urandom), $urandom_range(1, 8));
            if ($urandom_range(0, 49) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/seven_seg_capture.md
SEVEN_SEG_CAPTURE -- requirements
Module: seven_seg_capture

Interface
REQ-001 SHALL have parameter SETTLE, default 4, meaning the number of consecutive clk cycles (legal 1..255) an input pattern must hold before capture.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port an, input, 4 bits: digit enables, active low; an[i] low selects digit i. Synchronous to clk.
REQ-005 SHALL have port seg, input, 7 bits: segments, active low, seg[6]=A ... seg[0]=G.
REQ-006 SHALL have port dp, input, 1 bit: decimal point, active low.
REQ-007 SHALL have port digits, output, 16 bits: decoded frame, digit i at digits[4i+3:4i].
REQ-008 SHALL have port dps, output, 4 bits: dps[i]=1 when digit i's decimal point was lit (active high).
REQ-009 SHALL have port valid, output, 1 bit: one-cycle pulse when digits/dps/err load a new frame.
REQ-010 SHALL have port err, output, 1 bit: error flag of the most recently completed frame.

Function
REQ-011 SHALL decode seg: 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 1111111->4'hF (blank); any other pattern->4'hE and sets the frame error.
REQ-012 SHALL keep registered copy prev of {an,seg,dp}; change = current differs from prev.
REQ-013 SHALL hold a saturating 8-bit stable counter: cleared to 0 on change, else incremented, saturating at 255.
REQ-014 SHALL hold an armed flag: set on change, cleared on capture.
REQ-015 SHALL capture when armed, counter equals SETTLE-1 in the current cycle (the change cycle counts as counter 0), and exactly one an bit is low; with SETTLE=1, capture occurs in the change cycle itself.
REQ-016 A capture SHALL write decoded code and ~dp into shadow slot i and set seen[i]; a repeated capture of an already-seen digit overwrites its slot without error.
REQ-017 an=4'b1111 SHALL be idle: no capture, no error, counter still runs.
REQ-018 Two or more an bits low at the capture point SHALL set the frame error and capture nothing (armed still clears).
REQ-019 When a capture makes seen=4'b1111, on that same edge digits/dps SHALL load the shadow (including that capture), err SHALL load the frame error, valid SHALL be 1 for the next cycle only, and seen and frame error SHALL clear.
REQ-020 digits, dps and err SHALL change only on frame completion or reset; valid SHALL be 0 at all other times.
REQ-021 Once latched, the frame error SHALL persist until frame completion or reset.

Reset
REQ-022 On reset assertion, asynchronously: digits=16'hFFFF, dps=4'h0, valid=0, err=0, shadow=16'hFFFF with dps 0, seen=0, frame error=0, counter=0, armed=1, prev={4'hF,7'h7F,1'b1}.
REQ-023 Reset mid-frame SHALL discard all partial captures; the next frame starts with seen=0.

Verification
REQ-024 SETTLE=4; drive an=1110,1101,1011,0111 with patterns 4,3,2,1 (dp high), 8 cycles each -> single valid pulse, digits=16'h1234, dps=0, err=0.
REQ-025 SETTLE=4; hold digit 0 pattern for 3 cycles then switch to digit 1 -> no capture of digit 0, seen[0] remains 0, no valid.
REQ-026 Frame with digit 2 seg=1111110 and dp low on digit 0 -> valid, digits[11:8]=4'hE, dps=4'b0001, err=1; next clean frame -> err=0.
REQ-027 an=1100 held 8 cycles within a frame -> no capture for that dwell; frame completes with err=1.
REQ-028 Assert reset after 2 of 4 digits captured, then send a full 5678 frame -> outputs FFFF/0/0 during reset, then valid with digits=16'h5678, err=0.
REQ-029 SETTLE=1 with each digit held 1 cycle back-to-back -> valid one cycle after the 4th digit, correct digits.
